k_means_agg_collector: RTL and testbench
========================================

K_MEANS_AGG_COLLECTOR -- requirements
Module: k_means_agg_collector

Interface
REQ-001 SHALL have parameter NUM_CLUSTER_BITS, default 3, meaning log2 of maximum cluster count.
REQ-002 SHALL have parameter MAX_DEPTH_BITS, default 9, meaning log2 of maximum data dimension.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 accu_finish_i  input  1  sender reports a finished accumulation and waits for go.
REQ-007 agg_ready_o  output  1  go signal to the sender.
REQ-008 agg_valid_i  input  1  result word valid; no backpressure, every valid word is consumed.
REQ-009 agg_data_i  input  64  result word.
REQ-010 num_cluster_i  input  NUM_CLUSTER_BITS+1  active cluster count K.
REQ-011 data_dim_i  input  MAX_DEPTH_BITS+1  active dimension D.
REQ-012 rd_en_i, rd_cluster_i [NUM_CLUSTER_BITS-1:0], rd_dim_i [MAX_DEPTH_BITS-1:0]  input  sum read port.
REQ-013 rd_data_o  output  40  sum read data; rd_count_o  output  64  count of rd_cluster_i.
REQ-014 sse_o  output  64  signed SSE; result_valid_o  output  1  results complete.
REQ-015 clear_i  input  1  consumer releases results; err_o  output  1  sticky protocol error.

Function
REQ-016 FSM states SHALL be IDLE, GO, RX_CNT, RX_SUM, RX_SSE, HOLD.
REQ-017 IDLE->GO SHALL occur when accu_finish_i=1 and result_valid_o=0; K and D are latched on this transition.
REQ-018 In GO, agg_ready_o SHALL be 1; it SHALL drop on the cycle after the first agg_valid_i word is accepted, then go RX_CNT handling of that word applies.
REQ-019 Word order SHALL be K count words, then K*D sum words (cluster-major, dim-minor), then 1 SSE word.
REQ-020 RX_CNT: word i SHALL be stored into count register i; after word K-1 go RX_SUM (or RX_SSE if D=0).
REQ-021 RX_SUM: word SHALL write agg_data_i[39:0] to RAM address {cluster, dim}; dim wraps at D-1 and increments cluster; after cluster K-1, dim D-1 go RX_SSE.
REQ-022 RX_SSE: word SHALL be stored to sse_o; next state HOLD; result_valid_o=1 from the following cycle.
REQ-023 HOLD: result_valid_o SHALL stay 1 until clear_i=1, then return to IDLE with result_valid_o=0 next cycle.
REQ-024 If K=0 on the IDLE->GO transition, err_o SHALL set and FSM SHALL stay in IDLE.
REQ-025 agg_valid_i while in IDLE or HOLD SHALL set err_o and the word SHALL be dropped.
REQ-026 Read port latency SHALL be 1 cycle: rd_data_o and rd_count_o are registered from rd_en_i; rd_data_o holds when rd_en_i=0.
REQ-027 Reads in any state SHALL be legal; a read in the same cycle as a write to that address returns the old data.
REQ-028 accu_finish_i outside IDLE SHALL be ignored.
REQ-029 Bits [63:40] of sum words SHALL be ignored; counts and SSE SHALL be stored as full 64 bits, SSE as two's complement.
REQ-030 err_o SHALL clear only on reset or clear_i.

Reset
REQ-031 On rst_n=0, the block SHALL immediately set state IDLE, agg_ready_o=0, result_valid_o=0, err_o=0, sse_o=0, rd_data_o=0, rd_count_o=0, all counters and count registers 0; RAM contents are undefined.
REQ-032 Reset mid-receive SHALL abandon the transfer; after release the block SHALL accept a new accu_finish_i.

Verification
REQ-033 K=2, D=3: accu_finish_i=1 -> agg_ready_o=1; send counts 5,7, sums 1..6, SSE -9 -> rd(1,2)=6, rd_count(0)=5, sse_o=-9, result_valid_o=1.
REQ-034 K=1, D=0: counts 4, SSE 100 -> FSM skips RX_SUM; sse_o=100 after 2 words.
REQ-035 agg_valid_i pulse in IDLE -> err_o=1, no state change; clear_i -> err_o=0.
REQ-036 rst_n=0 after 3 sum words -> all outputs 0 at once; a new full transfer then completes correctly.
REQ-037 HOLD with accu_finish_i=1 -> agg_ready_o stays 0 until clear_i, then GO within 2 cycles.
REQ-038 Sum word 0xFFFF_FF12_3456_789A -> rd_data_o=0x12_3456_789A.

Source files
------------

// File: rtl/k_means_agg_collector.sv
// Collects one k-means accumulation result (K counts, K*D sums, SSE) from the
// accumulator into local storage and serves it through a 1-cycle read port.
module k_means_agg_collector #(
    parameter int NUM_CLUSTER_BITS = 3,
    parameter int MAX_DEPTH_BITS   = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        accu_finish_i,
    output logic                        agg_ready_o,
    input  logic                        agg_valid_i,
    input  logic [63:0]                 agg_data_i,
    input  logic [NUM_CLUSTER_BITS:0]   num_cluster_i,
    input  logic [MAX_DEPTH_BITS:0]     data_dim_i,
    input  logic                        rd_en_i,
    input  logic [NUM_CLUSTER_BITS-1:0] rd_cluster_i,
    input  logic [MAX_DEPTH_BITS-1:0]   rd_dim_i,
    output logic [39:0]                 rd_data_o,
    output logic [63:0]                 rd_count_o,
    output logic [63:0]                 sse_o,
    output logic                        result_valid_o,
    input  logic                        clear_i,
    output logic                        err_o
);
    localparam int NCB = NUM_CLUSTER_BITS;
    localparam int MDB = MAX_DEPTH_BITS;
    localparam int NC  = 1 << NCB;
    localparam int AW  = NCB + MDB;
    localparam logic [NCB-1:0] CL_ONE = 1;
    localparam logic [MDB-1:0] DM_ONE = 1;
    localparam logic [NCB:0]   K_ONE  = 1;
    localparam logic [MDB:0]   D_ONE  = 1;

    typedef enum logic [2:0] {IDLE, GO, RX_CNT, RX_SUM, RX_SSE, HOLD} state_t;

    state_t         state, state_nxt;
    logic [NCB:0]   k_q;
    logic [MDB:0]   d_q;
    logic [NCB-1:0] cl_idx;
    logic [MDB-1:0] dim_idx;
    logic [63:0]    count_q [NC];
    logic [39:0]    ram [1 << AW];

    logic start, last_cnt, last_dim, last_cl;
    logic cnt_wr, sum_wr, sse_wr, err_set;

    assign start    = (state == IDLE) && accu_finish_i && !result_valid_o;
    assign last_cnt = ({1'b0, cl_idx} == (k_q - K_ONE));
    assign last_cl  = last_cnt;
    assign last_dim = ({1'b0, dim_idx} == (d_q - D_ONE));

    // The word accepted while still in GO is count word 0.
    assign cnt_wr  = agg_valid_i && ((state == GO) || (state == RX_CNT));
    assign sum_wr  = agg_valid_i && (state == RX_SUM);
    assign sse_wr  = agg_valid_i && (state == RX_SSE);
    assign err_set = (start && (num_cluster_i == '0)) ||
                     (agg_valid_i && ((state == IDLE) || (state == HOLD)));

    assign agg_ready_o    = (state == GO);
    assign result_valid_o = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (start && (num_cluster_i != '0)) state_nxt = GO;
            GO, RX_CNT:
                if (agg_valid_i) begin
                    if (!last_cnt)       state_nxt = RX_CNT;
                    else if (d_q == '0)  state_nxt = RX_SSE;
                    else                 state_nxt = RX_SUM;
                end
            RX_SUM:
                if (agg_valid_i && last_dim && last_cl) state_nxt = RX_SSE;
            RX_SSE:
                if (agg_valid_i) state_nxt = HOLD;
            HOLD:
                if (clear_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word indexing: cl_idx walks the count words, then doubles as the
    // cluster index of the sum phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            d_q     <= '0;
            cl_idx  <= '0;
            dim_idx <= '0;
            sse_o   <= '0;
            for (int i = 0; i < NC; i++) count_q[i] <= '0;
        end else begin
            if (start && (num_cluster_i != '0)) begin
                k_q     <= num_cluster_i;
                d_q     <= data_dim_i;
                cl_idx  <= '0;
                dim_idx <= '0;
            end
            if (cnt_wr) begin
                count_q[cl_idx] <= agg_data_i;
                cl_idx          <= last_cnt ? '0 : cl_idx + CL_ONE;
            end
            if (sum_wr) begin
                if (last_dim) begin
                    dim_idx <= '0;
                    cl_idx  <= cl_idx + CL_ONE;
                end else begin
                    dim_idx <= dim_idx + DM_ONE;
                end
            end
            if (sse_wr) sse_o <= agg_data_i;
        end
    end

    // A new error event wins over a simultaneous release so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_o <= 1'b0;
        else if (err_set) err_o <= 1'b1;
        else if (clear_i) err_o <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (sum_wr) ram[{cl_idx, dim_idx}] <= agg_data_i[39:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o  <= '0;
            rd_count_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o  <= ram[{rd_cluster_i, rd_dim_i}];
            rd_count_o <= count_q[rd_cluster_i];
        end
    end

endmodule

// File: tb/tb_k_means_agg_collector.sv
// Bench for k_means_agg_collector: directed table, corner sequences, and
// randomized transfers against a word-list reference model.
module tb_k_means_agg_collector;
    localparam int NCB = 3;
    localparam int MDB = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              accu_finish_i = 1'b0;
    logic              agg_ready_o;
    logic              agg_valid_i = 1'b0;
    logic [63:0]       agg_data_i = '0;
    logic [NCB:0]      num_cluster_i = '0;
    logic [MDB:0]      data_dim_i = '0;
    logic              rd_en_i = 1'b0;
    logic [NCB-1:0]    rd_cluster_i = '0;
    logic [MDB-1:0]    rd_dim_i = '0;
    logic [39:0]       rd_data_o;
    logic [63:0]       rd_count_o;
    logic [63:0]       sse_o;
    logic              result_valid_o;
    logic              clear_i = 1'b0;
    logic              err_o;

    always #5 clk = ~clk;

    k_means_agg_collector #(.NUM_CLUSTER_BITS(NCB), .MAX_DEPTH_BITS(MDB)) dut (
        .clk(clk), .rst_n(rst_n), .accu_finish_i(accu_finish_i), .agg_ready_o(agg_ready_o),
        .agg_valid_i(agg_valid_i), .agg_data_i(agg_data_i), .num_cluster_i(num_cluster_i),
        .data_dim_i(data_dim_i), .rd_en_i(rd_en_i), .rd_cluster_i(rd_cluster_i),
        .rd_dim_i(rd_dim_i), .rd_data_o(rd_data_o), .rd_count_o(rd_count_o), .sse_o(sse_o),
        .result_valid_o(result_valid_o), .clear_i(clear_i), .err_o(err_o)
    );

    int checks = 0;
    int failures = 0;

    logic [63:0] tx_q[$];
    logic [63:0] m_cnt [8];
    logic [39:0] m_sum [8][512];
    logic [63:0] m_sse;

    typedef struct {
        int          k;
        int          d;
        logic [63:0] cbase;
        logic [63:0] cstep;
        logic [63:0] sbase;
        logic [63:0] sse;
        int          pc;
        int          pd;
        bit          chk_data;
        logic [39:0] exp_data;
        int          pcc;
        logic [63:0] exp_cnt;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: interpret the word list by position only.
    task automatic model_from_q(input int k, input int d);
        for (int j = 0; j < tx_q.size(); j++) begin
            if (j < k)              m_cnt[j] = tx_q[j];
            else if (j < k + k * d) m_sum[(j - k) / d][(j - k) % d] = tx_q[j][39:0];
            else                    m_sse = tx_q[j];
        end
    endtask

    task automatic build_lin(input int k, input int d, input logic [63:0] cbase,
                             input logic [63:0] cstep, input logic [63:0] sbase,
                             input logic [63:0] sse);
        tx_q.delete();
        for (int i = 0; i < k; i++) tx_q.push_back(cbase + cstep * 64'(i));
        for (int j = 0; j < k * d; j++) tx_q.push_back(sbase + 64'(j));
        tx_q.push_back(sse);
        model_from_q(k, d);
    endtask

    task automatic build_rand(input int k, input int d);
        tx_q.delete();
        for (int j = 0; j < k + k * d + 1; j++) tx_q.push_back({$urandom, $urandom});
        model_from_q(k, d);
    endtask

    task automatic start_xfer(input int k, input int d);
        int n;
        num_cluster_i = (NCB + 1)'(k);
        data_dim_i    = (MDB + 1)'(d);
        accu_finish_i = 1'b1;
        n = 0;
        step();
        while (!agg_ready_o && n < 8) begin
            step();
            n++;
        end
        chk("go_ready", 64'(agg_ready_o), 64'd1);
        accu_finish_i = 1'b0;
    endtask

    task automatic send_words();
        for (int i = 0; i < tx_q.size(); i++) begin
            agg_valid_i = 1'b1;
            agg_data_i  = tx_q[i];
            if (i == tx_q.size() - 1) chk("rv_before_sse", 64'(result_valid_o), 64'd0);
            step();
            if (i == 0) chk("ready_drop", 64'(agg_ready_o), 64'd0);
        end
        agg_valid_i = 1'b0;
        chk("rv_after_sse", 64'(result_valid_o), 64'd1);
    endtask

    task automatic rd(input int c, input int dd);
        rd_en_i      = 1'b1;
        rd_cluster_i = NCB'(c);
        rd_dim_i     = MDB'(dd);
        step();
        rd_en_i      = 1'b0;
    endtask

    task automatic check_model(input int k, input int d);
        chk("m_sse", sse_o, m_sse);
        for (int c = 0; c < k; c++) begin
            for (int dd = 0; dd < ((d > 0) ? d : 1); dd++) begin
                rd(c, dd);
                chk("m_count", rd_count_o, m_cnt[c]);
                if (d > 0) chk("m_sum", 64'(rd_data_o), 64'(m_sum[c][dd]));
            end
        end
    endtask

    task automatic release_results();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("rv_clear", 64'(result_valid_o), 64'd0);
        chk("err_clear", 64'(err_o), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(agg_ready_o), 64'd0);
        chk({tag, "_rv"}, 64'(result_valid_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
        chk({tag, "_sse"}, sse_o, 64'd0);
        chk({tag, "_rdata"}, 64'(rd_data_o), 64'd0);
        chk({tag, "_rcount"}, rd_count_o, 64'd0);
    endtask

    initial begin
        vecs[0] = '{k:2, d:3, cbase:64'd5, cstep:64'd2, sbase:64'd1, sse:-64'sd9,
                    pc:1, pd:2, chk_data:1'b1, exp_data:40'd6, pcc:0, exp_cnt:64'd5};
        vecs[1] = '{k:1, d:0, cbase:64'd4, cstep:64'd0, sbase:64'd0, sse:64'd100,
                    pc:0, pd:0, chk_data:1'b0, exp_data:40'd0, pcc:0, exp_cnt:64'd4};
        vecs[2] = '{k:8, d:2, cbase:64'd100, cstep:64'd2, sbase:64'h10,
                    sse:64'h7FFF_FFFF_FFFF_FFFF, pc:7, pd:1, chk_data:1'b1,
                    exp_data:40'h1F, pcc:7, exp_cnt:64'd114};
        vecs[3] = '{k:3, d:4, cbase:64'd0, cstep:64'd2, sbase:64'hFFFF_FF12_3456_789A,
                    sse:-64'sd1, pc:0, pd:0, chk_data:1'b1, exp_data:40'h12_3456_789A,
                    pcc:2, exp_cnt:64'd4};
        vecs[4] = '{k:1, d:512, cbase:64'd9, cstep:64'd0, sbase:64'd0, sse:64'd0,
                    pc:0, pd:511, chk_data:1'b1, exp_data:40'h1FF, pcc:0, exp_cnt:64'd9};

        #3;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Directed table.
        foreach (vecs[v]) begin
            build_lin(vecs[v].k, vecs[v].d, vecs[v].cbase, vecs[v].cstep,
                      vecs[v].sbase, vecs[v].sse);
            start_xfer(vecs[v].k, vecs[v].d);
            send_words();
            chk("tbl_sse", sse_o, vecs[v].sse);
            rd(vecs[v].pc, vecs[v].pd);
            if (vecs[v].chk_data) chk("tbl_rdata", 64'(rd_data_o), 64'(vecs[v].exp_data));
            rd(vecs[v].pcc, 0);
            chk("tbl_rcount", rd_count_o, vecs[v].exp_cnt);
            release_results();
        end

        // Stray word in IDLE: error, dropped, no state change.
        agg_valid_i = 1'b1;
        agg_data_i  = 64'hDEAD;
        step();
        agg_valid_i = 1'b0;
        chk("idle_word_err", 64'(err_o), 64'd1);
        chk("idle_word_ready", 64'(agg_ready_o), 64'd0);
        step();
        chk("idle_word_rv", 64'(result_valid_o), 64'd0);
        chk("idle_word_ready2", 64'(agg_ready_o), 64'd0);
        release_results();

        // K=0 start request is an error and stays in IDLE.
        num_cluster_i = '0;
        data_dim_i    = 10'd3;
        accu_finish_i = 1'b1;
        step();
        chk("k0_err", 64'(err_o), 64'd1);
        step();
        chk("k0_ready", 64'(agg_ready_o), 64'd0);
        accu_finish_i = 1'b0;
        release_results();

        // HOLD: stray word flags error, finish ignored until clear, then GO.
        build_lin(2, 3, 64'd5, 64'd2, 64'd1, -64'sd9);
        start_xfer(2, 3);
        send_words();
        accu_finish_i = 1'b1;
        agg_valid_i   = 1'b1;
        agg_data_i    = 64'h55;
        step();
        agg_valid_i   = 1'b0;
        chk("hold_word_err", 64'(err_o), 64'd1);
        chk("hold_word_rv", 64'(result_valid_o), 64'd1);
        chk("hold_word_sse", sse_o, m_sse);
        step();
        step();
        chk("hold_finish_ready", 64'(agg_ready_o), 64'd0);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("hold_clr_rv", 64'(result_valid_o), 64'd0);
        chk("hold_clr_err", 64'(err_o), 64'd0);
        chk("hold_clr_ready0", 64'(agg_ready_o), 64'd0);
        step();
        chk("hold_clr_go", 64'(agg_ready_o), 64'd1);
        accu_finish_i = 1'b0;
        send_words();
        check_model(2, 3);

        // Read data holds while rd_en_i is low.
        rd(1, 2);
        chk("rd_before_hold", 64'(rd_data_o), 64'd6);
        rd_cluster_i = '0;
        rd_dim_i     = '0;
        step();
        chk("rd_hold_data", 64'(rd_data_o), 64'd6);
        chk("rd_hold_count", rd_count_o, 64'd7);
        release_results();

        // Reset in the middle of the sum phase.
        build_lin(2, 3, 64'd5, 64'd2, 64'd1, -64'sd9);
        start_xfer(2, 3);
        for (int i = 0; i < 5; i++) begin
            agg_valid_i = 1'b1;
            agg_data_i  = tx_q[i];
            step();
        end
        agg_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        step();
        rst_n = 1'b1;
        step();
        build_lin(2, 3, 64'd21, 64'd1, 64'h40, 64'd77);
        start_xfer(2, 3);
        send_words();
        check_model(2, 3);
        release_results();

        // Randomized transfers against the reference model.
        for (int it = 0; it < 8; it++) begin
            int k, d;
            k = $urandom_range(1, 8);
            d = $urandom_range(0, 6);
            build_rand(k, d);
            start_xfer(k, d);
            send_words();
            check_model(k, d);
            release_results();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
